// File: rtl/rca_sum_accumulator.sv
// Multi-sample reduction stage behind the 16-bit ripple-carry adder: sums 1-16 adder results.
// Optional `RCA_ACC_SAT_EN clamps the accumulator on overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; acc/ovf hold the previous result
// ACC   | accepting samples until the programmed count is reached
// DONE  | result presented on out_valid until out_ready
module rca_sum_accumulator #(
    parameter int W  = 16,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    len,
    input  logic          in_valid,
    input  logic [W-1:0]  in_sum,
    input  logic          in_cout,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] acc,
    output logic          ovf,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [4:0]    cnt;
    logic [4:0]    cnt_inc;
    logic [4:0]    len_q;
    logic [AW-1:0] acc_q;
    logic          ovf_q;
    logic [AW:0]   sum_ext;
    logic [AW-1:0] acc_nxt;
    logic          accept;
    logic          last;

    assign accept  = (state == S_ACC) && in_valid;
    assign cnt_inc = cnt + 5'd1;
    assign last    = (cnt_inc == len_q);
    assign sum_ext = {1'b0, acc_q} + {1'b0, {(AW-W-1){1'b0}}, in_cout, in_sum};

`ifdef RCA_ACC_SAT_EN
    // once clamped the run stays at full scale
    assign acc_nxt = (sum_ext[AW] || ovf_q) ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
    assign acc_nxt = sum_ext[AW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)      state_nxt = S_ACC;
            S_ACC:  if (accept && last) state_nxt = S_DONE;
            S_DONE: if (out_ready)  state_nxt = S_IDLE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
        end else if (state == S_IDLE && start) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt   <= '0;
            len_q <= (len == 4'd0) ? 5'd16 : {1'b0, len};
        end else if (accept) begin
            acc_q <= acc_nxt;
            ovf_q <= ovf_q | sum_ext[AW];
            cnt   <= cnt_inc;
        end
    end

    assign in_ready  = (state == S_ACC);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_ACC) || (state == S_DONE);
    assign acc       = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Self-checking bench for rca_sum_accumulator: directed scenarios plus randomized runs
// checked against a plain-arithmetic running-sum model.
module tb_rca_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [15:0] in_sum;
    logic        in_cout;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] acc;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [16:0] smp[$];

    localparam int MOD = 1 << 20;

    rca_sum_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) hs_cnt = hs_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference: running sum with either wrap or clamp on carry out of 20 bits
    function automatic void model_add(inout int r, inout int o, input int s);
`ifdef RCA_ACC_SAT_EN
        if (o != 0 || r + s >= MOD) begin
            r = MOD - 1;
            o = 1;
        end else begin
            r = r + s;
        end
`else
        r = r + s;
        if (r >= MOD) begin
            r = r - MOD;
            o = 1;
        end
`endif
    endfunction

    task automatic do_run(input logic [3:0] l, input int gap_max, input int hold);
        int n, r, o, g;
        n = (l == 4'd0) ? 16 : int'(l);
        r = 0;
        o = 0;
        start = 1'b1;
        len = l;
        step();
        start = 1'b0;
        in_valid = 1'b0;
        hs_cnt = 0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || acc !== 20'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL run_start: in_ready=%b busy=%b acc=%h ovf=%b required 1 1 00000 0",
                     in_ready, busy, acc, ovf);
        end
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(0, gap_max);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                {in_cout, in_sum} = 17'($urandom);
                step();
                checks++;
                if (acc !== 20'(r) || in_ready !== 1'b1 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall: acc=%h in_ready=%b out_valid=%b required %h 1 0",
                             acc, in_ready, out_valid, 20'(r));
                end
            end
            in_valid = 1'b1;
            {in_cout, in_sum} = smp[i];
            step();
            model_add(r, o, int'(smp[i]));
            checks++;
            if (acc !== 20'(r) || ovf !== o[0]) begin
                errors++;
                $display("FAIL partial_sum[%0d]: acc=%h ovf=%b required %h %b",
                         i, acc, ovf, 20'(r), o[0]);
            end
            // keep valid high with junk data: must be ignored once the run completes
            {in_cout, in_sum} = 17'($urandom);
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_flags: out_valid=%b in_ready=%b busy=%b required 1 0 1",
                     out_valid, in_ready, busy);
        end
        for (int k = 0; k < hold; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || acc !== 20'(r) || ovf !== o[0]) begin
                errors++;
                $display("FAIL done_hold: out_valid=%b acc=%h ovf=%b required 1 %h %b",
                         out_valid, acc, ovf, 20'(r), o[0]);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || acc !== 20'(r) || ovf !== o[0]
            || hs_cnt != n) begin
            errors++;
            $display("FAIL run_end: out_valid=%b busy=%b acc=%h ovf=%b hs=%0d required 0 0 %h %b %0d",
                     out_valid, busy, acc, ovf, hs_cnt, 20'(r), o[0], n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || acc !== 20'd0 || ovf !== 1'b0
            || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b acc=%h ovf=%b busy=%b required 0 0 00000 0 0",
                     in_ready, out_valid, acc, ovf, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_acc();
        start = 1'b1;
        len = 4'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        {in_cout, in_sum} = 17'h1FFFF;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (acc !== 20'd0 || ovf !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_acc: acc=%h ovf=%b in_ready=%b busy=%b required 00000 0 0 0",
                     acc, ovf, in_ready, busy);
        end
        smp = '{17'h00011, 17'h00022, 17'h00033, 17'h00044};
        do_run(4'd4, 1, 0);
    endtask

    task automatic test_basic_sum();
        smp = '{17'h0FFFF, 17'h1FFFF, 17'h00001};
        do_run(4'd3, 0, 0);
    endtask

    task automatic test_len16();
        smp.delete();
        for (int i = 0; i < 16; i++) smp.push_back(17'h1FFFF);
        do_run(4'd0, 0, 1);
        checks++;
`ifdef RCA_ACC_SAT_EN
        if (acc !== 20'hFFFFF || ovf !== 1'b1) begin
`else
        if (acc !== 20'hFFFF0 || ovf !== 1'b1) begin
`endif
            errors++;
            $display("FAIL len16_result: acc=%h ovf=%b", acc, ovf);
        end
    endtask

    task automatic test_stalls();
        smp = '{17'h00005, 17'h0000A};
        do_run(4'd2, 3, 3);
        checks++;
        if (acc !== 20'h0000F) begin
            errors++;
            $display("FAIL stall_result: acc=%h required 0000f", acc);
        end
    endtask

    task automatic test_ignored();
        logic [19:0] keep;
        keep = acc;
        in_valid = 1'b1;
        {in_cout, in_sum} = 17'h12345;
        step();
        step();
        checks++;
        if (acc !== keep || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: acc=%h in_ready=%b busy=%b required %h 0 0",
                     acc, in_ready, busy, keep);
        end
        in_valid = 1'b0;
        start = 1'b1;
        len = 4'd3;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        {in_cout, in_sum} = 17'h00100;
        step();
        start = 1'b1;
        len = 4'd7;
        {in_cout, in_sum} = 17'h00020;
        step();
        start = 1'b0;
        {in_cout, in_sum} = 17'h00003;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || acc !== 20'h00123) begin
            errors++;
            $display("FAIL start_in_acc: out_valid=%b acc=%h required 1 00123", out_valid, acc);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        smp = '{17'h00002};
        do_run(4'd1, 0, 0);
        smp = '{17'h00003};
        do_run(4'd1, 0, 0);
        checks++;
        if (acc !== 20'h00003) begin
            errors++;
            $display("FAIL back_to_back: acc=%h required 00003", acc);
        end
    endtask

    task automatic test_random();
        int l, n;
        for (int t = 0; t < 20; t++) begin
            l = $urandom_range(0, 15);
            n = (l == 0) ? 16 : l;
            smp.delete();
            for (int i = 0; i < n; i++) smp.push_back(17'($urandom));
            do_run(4'(l), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        len = 4'd0;
        in_valid = 1'b0;
        in_sum = '0;
        in_cout = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_reset_mid_acc();
        test_basic_sum();
        test_len16();
        test_stalls();
        test_ignored();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
